uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clocks per serial bit; legal values are 4 to 65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; legal values are 5 to 8.
REQ-003 SHALL have parameter PARITY_MODE, default 0, meaning 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked; legal values are 1 or 2.
REQ-005 i_clk  input  1  single clock; all logic is on the rising edge.
REQ-006 i_rst_n  input  1  asynchronous, active-low reset.
REQ-007 i_rx_serial  input  1  asynchronous serial line, idle high.
REQ-008 o_rx_valid  output  1  received word available.
REQ-009 i_rx_ready  input  1  consumer accepts the word when o_rx_valid and i_rx_ready are both high.
REQ-010 o_rx_byte  output  DATA_BITS  received data, LSB first on the line.
REQ-011 o_parity_err  output  1  parity mismatch for the word presented.
REQ-012 o_frame_err  output  1  a stop bit was sampled low for the word presented.
REQ-013 o_overrun  output  1  sticky; a completed word was dropped because the holding register was full.
REQ-014 o_busy  output  1  high in every state except IDLE.

Function
REQ-015 SHALL pass i_rx_serial through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-016 SHALL implement the states IDLE, START, DATA, PARITY, STOP, DONE, and WAIT_IDLE.
REQ-017 IDLE: on a synchronized low, SHALL clear the bit counter and go to START.
REQ-018 START: at count CLKS_PER_BIT/2 (integer divide), SHALL go to DATA if the line is low, otherwise return to IDLE (glitch rejection).
REQ-019 Each later bit SHALL be sampled after exactly CLKS_PER_BIT clocks from the previous sample (mid-bit).
REQ-020 DATA: SHALL sample DATA_BITS bits LSB-first into a shift register.
REQ-021 After DATA, SHALL go to PARITY if PARITY_MODE is not 0, otherwise to STOP.
REQ-022 PARITY: SHALL sample one bit; error = (XOR of data bits XOR parity bit) != (PARITY_MODE==2).
REQ-023 STOP: SHALL sample STOP_BITS bits; any sampled low sets the frame error.
REQ-024 DONE: lasts one cycle; SHALL load o_rx_byte and both error flags and set o_rx_valid, unless o_rx_valid is already high and i_rx_ready is low in that cycle.
REQ-025 In that blocked case, SHALL drop the new word, leave the held outputs unchanged, and set o_overrun.
REQ-026 A handshake and a DONE load in the same cycle SHALL load the new word with o_rx_valid staying high; this is not an overrun.
REQ-027 Latency: o_rx_valid SHALL rise 2 cycles after the final stop-bit sample cycle.
REQ-028 o_rx_valid SHALL fall on the cycle after a handshake with no new load.
REQ-029 After DONE, on a frame error SHALL go to WAIT_IDLE and stay there until the synchronized line is high, which handles break conditions; otherwise SHALL go to IDLE.
REQ-030 o_overrun SHALL clear only on reset.
REQ-031 Any unreachable state encoding SHALL return to IDLE.

Reset
REQ-032 On i_rst_n low, SHALL immediately set: state IDLE, counters 0, synchronizer flops 1, o_rx_valid 0, o_rx_byte 0, o_parity_err 0, o_frame_err 0, o_overrun 0, o_busy 0.
REQ-033 Reset in mid-frame SHALL discard the partial word; after release the receiver SHALL restart at IDLE and not assert o_rx_valid for the aborted frame.

Structure
REQ-034 SHALL place the state encoding and the PARITY_NONE/EVEN/ODD constants in the shared package uart_pkg.
REQ-035 SHALL use one sub-module, uart_sync (parametrised 2-flop synchronizer with a reset value), instantiated for i_rx_serial.

Verification
REQ-036 Bench with CLKS_PER_BIT=16, 8N1, i_rx_ready=1: send 0xA5; o_rx_byte=0xA5 with no error flags and o_rx_valid high for 1 cycle.
REQ-037 Bench with DATA_BITS=7, PARITY_MODE=1: send 0x55 with parity 1 (wrong); o_rx_byte=0x55 and o_parity_err=1.
REQ-038 Bench with 8N2: send 0x3C with the second stop bit low; o_frame_err=1, o_rx_valid is not asserted again, and the next frame after the line returns high is received correctly.
REQ-039 Bench with a 5-clock low glitch on an idle line: no o_rx_valid, and the state is back in IDLE within 9 cycles.
REQ-040 Bench with i_rx_ready=0: send 0x11 then 0x22; o_rx_byte=0x11 and o_overrun=1; after the handshake o_rx_valid falls.
REQ-041 Bench asserting i_rst_n low during DATA of 0xFF: all outputs go to 0 immediately, and a following 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding, parity modes and the
// parity check used when the parity bit is sampled.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_DONE      = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_error(input logic [7:0] data,
                                        input logic       pbit,
                                        input int         mode);
    return ((^data) ^ pbit) != (mode == PARITY_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_cfg_if.sv
// Word-output handshake of the UART receiver: received word, error flags and
// the valid/ready pair between receiver (master) and consumer (slave).
interface uart_rx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 o_rx_valid;
  logic                 i_rx_ready;
  logic [DATA_BITS-1:0] o_rx_byte;
  logic                 o_parity_err;
  logic                 o_frame_err;

  modport master (
    output o_rx_valid,
    output o_rx_byte,
    output o_parity_err,
    output o_frame_err,
    input  i_rx_ready
  );

  modport slave (
    input  o_rx_valid,
    input  o_rx_byte,
    input  o_parity_err,
    input  o_frame_err,
    output i_rx_ready
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer, one independent chain per bit, with a per-bit
// reset value so an idle-high line does not look like a start bit.
module uart_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        meta_reg <= RESET_VAL[gi];
        sync_reg <= RESET_VAL[gi];
      end else begin
        meta_reg <= i_d[gi];
        sync_reg <= meta_reg;
      end
    end

    assign o_q[gi] = sync_reg;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: mid-bit sampling, optional parity, 1/2 stop bits,
// one-word holding register with valid/ready output and sticky overrun.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_rx_serial,
  uart_rx_cfg_if.master rx_if,
  output logic          o_overrun,
  output logic          o_busy
);

  localparam logic [15:0] HALF_CNT  = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP = 4'(STOP_BITS - 1);

  logic rx_sync;

  rx_state_e            state_reg,   state_next;
  logic [15:0]          cnt_reg,     cnt_next;
  logic [3:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic                 par_err_reg, par_err_next;
  logic                 frm_err_reg, frm_err_next;
  logic                 valid_reg,   valid_next;
  logic [DATA_BITS-1:0] byte_reg,    byte_next;
  logic                 perr_reg,    perr_next;
  logic                 ferr_reg,    ferr_next;
  logic                 overrun_reg, overrun_next;

  uart_sync #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_rx_serial),
    .o_q    (rx_sync)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      valid_reg   <= 1'b0;
      byte_reg    <= '0;
      perr_reg    <= 1'b0;
      ferr_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      par_err_reg <= par_err_next;
      frm_err_reg <= frm_err_next;
      valid_reg   <= valid_next;
      byte_reg    <= byte_next;
      perr_reg    <= perr_next;
      ferr_reg    <= ferr_next;
      overrun_reg <= overrun_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    par_err_next = par_err_reg;
    frm_err_next = frm_err_reg;
    valid_next   = valid_reg;
    byte_next    = byte_reg;
    perr_next    = perr_reg;
    ferr_next    = ferr_reg;
    overrun_next = overrun_reg;

    if (valid_reg && rx_if.i_rx_ready) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      ST_IDLE: begin
        if (!rx_sync) begin
          cnt_next     = '0;
          bit_cnt_next = '0;
          par_err_next = 1'b0;
          frm_err_next = 1'b0;
          state_next   = ST_START;
        end
      end

      // A start bit still low at its midpoint is genuine; anything else is a glitch.
      ST_START: begin
        if (cnt_reg == HALF_CNT) begin
          cnt_next   = '0;
          state_next = rx_sync ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_DATA: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt_reg == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_PARITY: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next     = '0;
          par_err_next = parity_error(8'(shift_reg), rx_sync, PARITY_MODE);
          state_next   = ST_STOP;
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      ST_STOP: begin
        if (cnt_reg == LAST_CNT) begin
          cnt_next = '0;
          if (!rx_sync) begin
            frm_err_next = 1'b1;
          end
          if (bit_cnt_reg == LAST_STOP) begin
            bit_cnt_next = '0;
            state_next   = ST_DONE;
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else begin
          cnt_next = cnt_reg + 16'd1;
        end
      end

      // A held word that is not being taken this cycle wins over the new one.
      ST_DONE: begin
        if (valid_reg && !rx_if.i_rx_ready) begin
          overrun_next = 1'b1;
        end else begin
          valid_next = 1'b1;
          byte_next  = shift_reg;
          perr_next  = par_err_reg;
          ferr_next  = frm_err_reg;
        end
        state_next = frm_err_reg ? ST_WAIT_IDLE : ST_IDLE;
      end

      ST_WAIT_IDLE: begin
        if (rx_sync) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign rx_if.o_rx_valid   = valid_reg;
  assign rx_if.o_rx_byte    = byte_reg;
  assign rx_if.o_parity_err = perr_reg;
  assign rx_if.o_frame_err  = ferr_reg;
  assign o_overrun          = overrun_reg;
  assign o_busy             = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receivers (8N1, 7E1, 8N2, 5O1) at 16 clocks per
// bit, directed corner cases plus random frames scored against a frame model.
module tb_uart_rx_cfg;

  localparam int CPB   = 16;
  localparam int DB[4] = '{8, 7, 8, 5};
  localparam int PM[4] = '{0, 1, 0, 2};
  localparam int SB[4] = '{1, 1, 2, 1};

  typedef struct {
    int         inst;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    int         start_cyc;
    int         lat;
    bit         chk_lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rx_line;
  logic [3:0] rdy;
  int         cyc     = 0;
  int         n_total = 0;
  int         n_bad   = 0;
  int         vcnt[4] = '{0, 0, 0, 0};
  exp_t       exp_q[$];

  wire [3:0] vld, perr_w, ferr_w, ovr_w, busy_w;
  wire [7:0] byte_w [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_rx_cfg_if #(.DATA_BITS(7)) if1 ();
  uart_rx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_rx_cfg_if #(.DATA_BITS(5)) if3 ();

  assign if0.i_rx_ready = rdy[0];
  assign if1.i_rx_ready = rdy[1];
  assign if2.i_rx_ready = rdy[2];
  assign if3.i_rx_ready = rdy[3];

  assign vld    = {if3.o_rx_valid, if2.o_rx_valid, if1.o_rx_valid, if0.o_rx_valid};
  assign perr_w = {if3.o_parity_err, if2.o_parity_err, if1.o_parity_err, if0.o_parity_err};
  assign ferr_w = {if3.o_frame_err, if2.o_frame_err, if1.o_frame_err, if0.o_frame_err};
  assign byte_w[0] = if0.o_rx_byte;
  assign byte_w[1] = {1'b0, if1.o_rx_byte};
  assign byte_w[2] = if2.o_rx_byte;
  assign byte_w[3] = {3'b000, if3.o_rx_byte};

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_rx0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_line[0]), .rx_if(if0),
    .o_overrun(ovr_w[0]), .o_busy(busy_w[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(1)) u_rx1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_line[1]), .rx_if(if1),
    .o_overrun(ovr_w[1]), .o_busy(busy_w[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_rx2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_line[2]), .rx_if(if2),
    .o_overrun(ovr_w[2]), .o_busy(busy_w[2]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(2), .STOP_BITS(1)) u_rx3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_serial(rx_line[3]), .rx_if(if3),
    .o_overrun(ovr_w[3]), .o_busy(busy_w[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Start edge -> 2 sync flops + 1 IDLE cycle, half bit to the start midpoint,
  // one full bit per later sample, then 2 cycles until valid is visible.
  function automatic int exp_latency(input int inst);
    return 3 + CPB / 2 + CPB * (DB[inst] + ((PM[inst] != 0) ? 1 : 0) + SB[inst]) + 2;
  endfunction

  task automatic send_frame(input int inst, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stops, input bit push, input bit chk_lat,
                            input logic idle_lvl);
    exp_t       e;
    logic       line_bits[$];
    logic [7:0] dm;
    int         ones;
    dm = data & 8'((1 << DB[inst]) - 1);
    line_bits.push_back(1'b0);
    for (int i = 0; i < DB[inst]; i++) line_bits.push_back(data[i]);
    if (PM[inst] != 0) line_bits.push_back(pbit);
    for (int s = 0; s < SB[inst]; s++) line_bits.push_back(stops[s]);
    ones      = $countones(dm) + (pbit ? 1 : 0);
    e.inst    = inst;
    e.data    = dm;
    e.perr    = (PM[inst] != 0) && ((ones % 2) != ((PM[inst] == 2) ? 1 : 0));
    e.ferr    = 1'b0;
    for (int s = 0; s < SB[inst]; s++) if (!stops[s]) e.ferr = 1'b1;
    e.lat     = exp_latency(inst);
    e.chk_lat = chk_lat;
    @(negedge clk);
    e.start_cyc = cyc;
    if (push) exp_q.push_back(e);
    $display("tx inst=%0d data=%02h pbit=%0b stops=%02b kept=%0b", inst, dm, pbit, stops, push);
    foreach (line_bits[k]) begin
      rx_line[inst] = line_bits[k];
      repeat (CPB) @(negedge clk);
    end
    rx_line[inst] = idle_lvl;
    repeat (2 * CPB) @(negedge clk);
  endtask

  // Scoreboard: every accepted word must match the oldest expected frame.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) vcnt[i]++;
        if (rst_n && vld[i] && rdy[i]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("spurious_valid%0d", i), 32'(vld[i]), 32'd0);
          end else begin
            e = exp_q.pop_front();
            $display("rx inst=%0d data=%02h perr=%0b ferr=%0b lat=%0d",
                     i, byte_w[i], perr_w[i], ferr_w[i], cyc - e.start_cyc);
            check("word_inst", 32'(i), 32'(e.inst));
            check($sformatf("data%0d", i), 32'(byte_w[i]), 32'(e.data));
            check($sformatf("perr%0d", i), 32'(perr_w[i]), 32'(e.perr));
            check($sformatf("ferr%0d", i), 32'(ferr_w[i]), 32'(e.ferr));
            if (e.chk_lat) check($sformatf("latency%0d", i), 32'(cyc - e.start_cyc), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    int         v0;
    int         idle_at;
    int         inst;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;

    rst_n   = 1'b0;
    rx_line = '1;
    rdy     = '1;
    repeat (4) @(negedge clk);
    check("rst_valid", 32'(vld[0]), 32'd0);
    check("rst_busy", 32'(busy_w), 32'd0);
    check("rst_overrun", 32'(ovr_w), 32'd0);
    check("rst_byte", 32'(byte_w[0]), 32'd0);
    check("rst_flags", 32'({perr_w[0], ferr_w[0]}), 32'd0);
    rst_n = 1'b1;
    repeat (CPB) @(negedge clk);

    // 8N1 0xA5, valid for exactly one cycle
    v0 = vcnt[0];
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
    check("a5_valid_cycles", 32'(vcnt[0] - v0), 32'd1);

    // 7E1 0x55 with wrong parity bit
    send_frame(1, 8'h55, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
    check("p55_byte", 32'(byte_w[1]), 32'h55);
    check("p55_perr", 32'(perr_w[1]), 32'd1);

    // 8N2 0x3C, second stop low, line held low as a break
    v0 = vcnt[2];
    send_frame(2, 8'h3C, 1'b0, 2'b01, 1'b1, 1'b1, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("brk_wait_busy", 32'(busy_w[2]), 32'd1);
    check("brk_ferr", 32'(ferr_w[2]), 32'd1);
    check("brk_valid_cycles", 32'(vcnt[2] - v0), 32'd1);
    rx_line[2] = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("brk_idle", 32'(busy_w[2]), 32'd0);
    send_frame(2, 8'hC3, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1);

    // 5-clock glitch on the idle line
    v0 = vcnt[0];
    @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_seen", 32'(busy_w[0]), 32'd1);
    rx_line[0] = 1'b1;
    idle_at = -1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (!busy_w[0] && idle_at < 0) idle_at = k;
    end
    check("glitch_idle_in_9", 32'(idle_at >= 1 && idle_at <= 9), 32'd1);
    repeat (2 * CPB) @(negedge clk);
    check("glitch_no_valid", 32'(vcnt[0] - v0), 32'd0);

    // Consumer stalled: second word dropped, overrun set
    @(posedge clk);
    #1 rdy[0] = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b1, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("ovr_valid_held", 32'(vld[0]), 32'd1);
    check("ovr_byte_held", 32'(byte_w[0]), 32'h11);
    check("ovr_flag", 32'(ovr_w[0]), 32'd1);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("ovr_valid_fall", 32'(vld[0]), 32'd0);
    check("ovr_sticky", 32'(ovr_w[0]), 32'd1);

    // Reset in the middle of 0xFF data bits
    v0 = vcnt[0];
    @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check("mid_busy", 32'(busy_w[0]), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("mrst_valid", 32'(vld[0]), 32'd0);
    check("mrst_byte", 32'(byte_w[0]), 32'd0);
    check("mrst_flags", 32'({perr_w[0], ferr_w[0]}), 32'd0);
    check("mrst_overrun", 32'(ovr_w[0]), 32'd0);
    check("mrst_busy", 32'(busy_w[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("mrst_no_valid", 32'(vcnt[0] - v0), 32'd0);
    send_frame(0, 8'h81, 1'b0, 2'b11, 1'b1, 1'b1, 1'b1);

    // Random frames on all four receivers
    for (int n = 0; n < 24; n++) begin
      inst  = int'($urandom_range(0, 3));
      data  = 8'($urandom);
      pbit  = 1'($urandom_range(0, 1));
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_frame(inst, data, pbit, stops, 1'b1, 1'b1, 1'b1);
    end

    repeat (4 * CPB) @(negedge clk);
    check("pending_words", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
